// File: rtl/axis_master_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_master_fifo_if                                                      |
// | Backend valid/ready port and AXI-Stream master port of the bridge.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface axis_master_fifo_if;
  logic [31:0] bk_data;
  logic [1:0]  bk_user;
  logic        bk_last;
  logic        bk_valid;
  logic        bk_ready;
  logic        axis_tvalid;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tstrb;
  logic [3:0]  axis_tkeep;
  logic        axis_tlast;
  logic [1:0]  axis_tuser;
  logic        axis_tready;

  modport master (
    input  bk_data, bk_user, bk_last, bk_valid,
    output bk_ready,
    output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
    input  axis_tready
  );

  modport slave (
    output bk_data, bk_user, bk_last, bk_valid,
    input  bk_ready,
    input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
    output axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_master_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_master_fifo                                                         |
// | Backend-to-AXI-Stream master bridge: DEPTH-entry FIFO + output register. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module axis_master_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  axis_master_fifo_if.master          bus,
  output logic [$clog2(DEPTH+2)-1:0]  occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+2);
  localparam int WW = 35;

  localparam logic [AW-1:0] c_ptr_one   = AW'(1);
  localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
  localparam logic [AW:0]   c_cnt_zero  = '0;
  localparam logic [AW:0]   c_cnt_full  = (AW+1)'(DEPTH);
  localparam logic [3:0]    c_byte_mask = 4'hF;

  logic [WW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_tvalid;
  logic [WW-1:0] r_out;
  logic [CW-1:0] r_occupancy;

  logic [WW-1:0] w_bk_word;
  logic [WW-1:0] w_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_out_free;
  logic          w_load_fifo;
  logic          w_bypass;
  logic          w_fifo_wr;
  logic          w_tvalid_next;
  logic [AW:0]   w_count_next;
  logic [CW-1:0] w_occ_next;

  assign w_bk_word    = {bus.bk_last, bus.bk_user, bus.bk_data};
  assign w_head       = r_mem[r_rd_ptr];
  assign w_fifo_full  = (r_count == c_cnt_full);
  assign w_fifo_empty = (r_count == c_cnt_zero);

  // Ready depends only on registered state (and reset), never on axis_tready.
  assign bus.bk_ready = axi_aresetn & ~w_fifo_full;

  assign w_push      = bus.bk_valid & bus.bk_ready;
  assign w_out_free  = ~r_tvalid | bus.axis_tready;
  assign w_load_fifo = w_out_free & ~w_fifo_empty;
  assign w_bypass    = w_out_free & w_fifo_empty & w_push;
  assign w_fifo_wr   = w_push & ~w_bypass;

  always_comb begin
    w_tvalid_next = r_tvalid;
    w_count_next  = r_count;
    if (w_out_free) begin
      w_tvalid_next = w_load_fifo | w_bypass;
    end
    if (w_fifo_wr && !w_load_fifo) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_fifo_wr && w_load_fifo) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  assign w_occ_next = CW'(w_count_next) + CW'(w_tvalid_next);

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge axi_aclk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= w_bk_word;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tvalid    <= 1'b0;
      r_out       <= '0;
      r_occupancy <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_load_fifo) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
        r_out    <= w_head;
      end else if (w_bypass) begin
        r_out    <= w_bk_word;
      end
      r_count     <= w_count_next;
      r_tvalid    <= w_tvalid_next;
      r_occupancy <= w_occ_next;
    end
  end

  assign bus.axis_tvalid = r_tvalid;
  assign bus.axis_tdata  = r_out[31:0];
  assign bus.axis_tuser  = r_out[33:32];
  assign bus.axis_tlast  = r_out[34];
  assign bus.axis_tstrb  = c_byte_mask;
  assign bus.axis_tkeep  = c_byte_mask;
  assign occupancy       = r_occupancy;

endmodule
`default_nettype wire

// File: doc/axis_master_fifo.md
Name: axis_master_fifo

Overview:
Backend-to-AXI-Stream master bridge with elastic buffering. It accepts words from a backend producer on a valid/ready interface and drives an AXI-Stream master port. That port feeds a downstream AXI-Stream slave stage, which converts the stream back to a backend interface. A DEPTH-entry FIFO plus one output register absorbs downstream stalls, so the backend is not held for a full handshake per word.

Parameters:
DEPTH, 4, FIFO entries excluding output register; power of two, >= 2
AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden)
CW, $clog2(DEPTH+2), occupancy counter width (derived)

Ports:
axi_aclk  input  1  clock
axi_aresetn  input  1  reset, asynchronous, active-low
bk_data  input  32  backend word
bk_user  input  2  backend sideband, forwarded to tuser
bk_last  input  1  backend end-of-packet, forwarded to tlast
bk_valid  input  1  backend word valid
bk_ready  output  1  bridge can accept a word
axis_tvalid  output  1  AXI-Stream valid
axis_tdata  output  32  AXI-Stream data
axis_tstrb  output  4  constant 4'hF
axis_tkeep  output  4  constant 4'hF
axis_tlast  output  1  AXI-Stream last
axis_tuser  output  2  AXI-Stream user
axis_tready  input  1  downstream ready
occupancy  output  CW  words held (FIFO entries + axis_tvalid), 0..DEPTH+1

Behaviour:
- Clock is axi_aclk. Reset is axi_aresetn, asynchronous, active-low.
- Reset values: axis_tvalid=0, axis_tdata=0, axis_tlast=0, axis_tuser=0, occupancy=0, FIFO pointers=0.
- bk_ready is 0 while reset is asserted.
- Each entry stores {bk_last, bk_user, bk_data} (35 bits).
- bk_ready = ~fifo_full, where fifo_full is derived from registered FIFO count == DEPTH. There is no combinational path from axis_tready to bk_ready.
- push = bk_valid & bk_ready. pop_out = axis_tvalid & axis_tready. out_free = ~axis_tvalid | axis_tready.
- Output register update, priority order:
  1. out_free and FIFO non-empty: load FIFO head, FIFO pops, axis_tvalid=1.
  2. out_free, FIFO empty, push: bypass, load backend word directly, axis_tvalid=1, FIFO not written.
  3. out_free, nothing available: axis_tvalid=0; data/last/user hold their last values.
  4. Otherwise (tvalid=1, tready=0): all axis_* outputs hold stable (AXI-Stream rule).
- FIFO write: push and not bypassed. Simultaneous FIFO write and pop leaves the FIFO count unchanged. Pointers wrap modulo DEPTH.
- Ordering: strict FIFO order. The bypass is used only when the FIFO is empty, so words are never reordered.
- Latency: word accepted at edge N appears on axis_* after edge N when the bridge is empty (one cycle). Otherwise it appears behind prior words.
- Throughput: one word per cycle sustained when axis_tready is held at 1.
- occupancy is registered: occupancy_next = FIFO count_next + axis_tvalid_next.
- Full condition: FIFO count == DEPTH and output register valid gives occupancy = DEPTH+1 and bk_ready=0.
  - If axis_tready=1 in that cycle: the head moves to the output register, bk_ready rises next cycle.
  - A push is never lost or overwritten.
- Empty condition: axis_tvalid=0 and occupancy=0. The backend may push without restriction.
- Reset mid-operation: all buffered words are discarded immediately (asynchronous). After release, behaviour is as from power-up.
- axis_tready asserted while axis_tvalid=0 has no effect.
- bk_valid may drop without a handshake; nothing is captured.

Test Plan:
1. Reset, single push bk_data=32'hA5A5_0001, user=2'b10, last=1, tready=1 -> tvalid=1 one cycle later with tdata=A5A5_0001, tuser=2, tlast=1; tvalid=0 next cycle; occupancy 0->1->0.
2. tready=0, push 6 words 0..5 (DEPTH=4) -> 5 accepted, bk_ready=0 after 5th, occupancy=5. Raise tready -> outputs 0,1,2,3,4 in order; bk_ready=1 one cycle after first pop; 6th word then accepted and emitted last.
3. Back-to-back streaming of 16 words with tready=1 and bk_valid=1 -> one word per cycle, bk_ready constantly 1, occupancy never exceeds 1, data order preserved.
4. Stall hold: tvalid=1 with tdata=32'hDEAD_BEEF, tready=0 for 7 cycles while pushing new words -> tdata/tuser/tlast unchanged for all 7 cycles.
5. Random tready (50%) with random bk_valid over 1000 words -> scoreboard matches data/user/last, no loss/duplication; tstrb=tkeep=4'hF throughout.
6. Assert axi_aresetn low with occupancy=4 -> tvalid=0 and occupancy=0 immediately (asynchronous), without waiting for a clock edge. After release, push 32'h1234 -> emitted as first word; no stale data.
